// File: rtl/sme_rng_ctrl.sv
// Sequencer/arbiter for the SME random-number source: runs the post-reset warm-up,
// hands each fresh RNG word to exactly one requester round-robin, and enforces a settle gap.
module sme_rng_ctrl #(
  parameter int NREQ         = 2,
  parameter int WARMUP       = 8,
  parameter int SETTLE       = 1,
  parameter int IDLE_REFRESH = 16
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  output logic            g_clk_req,
  input  logic            flush,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            rng_update,
  output logic            rng_ready
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW = (IDLE_REFRESH > 1) ? $clog2(IDLE_REFRESH) : 1;

  typedef enum logic [1:0] {
    ST_WARM   = 2'd0,
    ST_READY  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      warm_cnt, warm_nxt;
  logic [3:0]      settle_cnt, settle_nxt;
  logic [IW-1:0]   idle_cnt, idle_nxt;
  logic [LW-1:0]   last, last_nxt;

  logic [2*NREQ-1:0] req_rot;
  logic              pick_vld;
  logic [LW-1:0]     pick;
  logic [NREQ-1:0]   gnt_nxt;
  logic              upd;

  // Rotate the doubled request vector so bit 0 is the requester just after `last`;
  // scanning downwards leaves the lowest rotated hit, i.e. the first in round-robin order.
  always_comb begin
    req_rot  = {req, req} >> (int'(last) + 1);
    pick_vld = 1'b0;
    pick     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick_vld = 1'b1;
        pick     = LW'((int'(last) + 1 + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    warm_nxt   = warm_cnt;
    settle_nxt = settle_cnt;
    idle_nxt   = idle_cnt;
    last_nxt   = last;
    gnt_nxt    = '0;
    upd        = 1'b0;

    case (state)
      ST_WARM: begin
        upd = 1'b1;
        if (warm_cnt == 8'(WARMUP - 1)) begin
          warm_nxt  = '0;
          state_nxt = ST_SETTLE;
        end else begin
          warm_nxt = warm_cnt + 8'd1;
        end
      end
      ST_READY: begin
        if (pick_vld) begin
          for (int j = 0; j < NREQ; j++) gnt_nxt[j] = (pick == LW'(j));
          upd       = 1'b1;
          last_nxt  = pick;
          idle_nxt  = '0;
          state_nxt = ST_SETTLE;
        end else if ((IDLE_REFRESH != 0) && (idle_cnt == IW'(IDLE_REFRESH - 1))) begin
          upd       = 1'b1;
          idle_nxt  = '0;
          state_nxt = ST_SETTLE;
        end else begin
          idle_nxt = idle_cnt + IW'(1);
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == 4'(SETTLE - 1)) begin
          settle_nxt = '0;
          state_nxt  = ST_READY;
        end else begin
          settle_nxt = settle_cnt + 4'd1;
        end
      end
      default: state_nxt = ST_WARM;
    endcase

    // A flush kills whatever this cycle would have done; the pointer survives.
    if (flush) begin
      state_nxt  = ST_WARM;
      warm_nxt   = '0;
      settle_nxt = '0;
      idle_nxt   = '0;
      last_nxt   = last;
      gnt_nxt    = '0;
      upd        = 1'b0;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state      <= ST_WARM;
      warm_cnt   <= '0;
      settle_cnt <= '0;
      idle_cnt   <= '0;
      last       <= LW'(NREQ - 1);
    end else begin
      state      <= state_nxt;
      warm_cnt   <= warm_nxt;
      settle_cnt <= settle_nxt;
      idle_cnt   <= idle_nxt;
      last       <= last_nxt;
    end
  end

  // The reset state is WARM, which would otherwise strobe update while still held in reset.
  assign rng_update = upd & g_resetn;
  assign gnt        = gnt_nxt;
  assign rng_ready  = (state != ST_WARM);
  assign g_clk_req  = (state != ST_READY) | (|req) | (IDLE_REFRESH != 0);

endmodule

// File: tb/tb_sme_rng_ctrl.sv
// Self-checking bench for sme_rng_ctrl: per-cycle scoreboard against a behavioural model,
// plus directed checks of warm-up, round-robin order, idle refresh, flush and async reset.
module tb_sme_rng_ctrl;

  localparam int NREQ         = 2;
  localparam int WARMUP       = 8;
  localparam int SETTLE       = 1;
  localparam int IDLE_REFRESH = 16;
  localparam int EW           = NREQ + 3;

  logic            g_clk;
  logic            g_resetn;
  logic            g_clk_req;
  logic            flush;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            rng_update;
  logic            rng_ready;

  sme_rng_ctrl #(
    .NREQ(NREQ), .WARMUP(WARMUP), .SETTLE(SETTLE), .IDLE_REFRESH(IDLE_REFRESH)
  ) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .g_clk_req(g_clk_req), .flush(flush),
    .req(req), .gnt(gnt), .rng_update(rng_update), .rng_ready(rng_ready)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: 0=WARM 1=READY 2=SETTLE
  int m_state, m_warm, m_settle, m_idle, m_last;
  int n_state, n_warm, n_settle, n_idle, n_last;
  logic [EW-1:0] sb[$];

  logic [NREQ-1:0] log_gnt [0:255];
  logic            log_upd [0:255];
  logic            log_rdy [0:255];
  int              cyc;

  task automatic model_reset();
    m_state = 0; m_warm = 0; m_settle = 0; m_idle = 0; m_last = NREQ - 1;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r, input logic f);
    logic [NREQ-1:0] g;
    logic u, rdy, ck;
    int pick, k;
    g = '0; u = 1'b0; pick = -1;
    n_state = m_state; n_warm = m_warm; n_settle = m_settle; n_idle = m_idle; n_last = m_last;
    if (m_state == 0) begin
      u = 1'b1;
      if (m_warm == WARMUP - 1) begin n_state = 2; n_warm = 0; end
      else n_warm = m_warm + 1;
    end else if (m_state == 1) begin
      for (int i = 1; i <= NREQ; i++) begin
        k = (m_last + i) % NREQ;
        if (pick < 0 && ((r >> k) & 1) != 0) pick = k;
      end
      if (pick >= 0) begin
        g = 1 << pick; u = 1'b1; n_last = pick; n_idle = 0; n_state = 2;
      end else if (IDLE_REFRESH != 0 && m_idle == IDLE_REFRESH - 1) begin
        u = 1'b1; n_idle = 0; n_state = 2;
      end else begin
        n_idle = m_idle + 1;
      end
    end else begin
      if (m_settle == SETTLE - 1) begin n_settle = 0; n_state = 1; end
      else n_settle = m_settle + 1;
    end
    if (f) begin
      g = '0; u = 1'b0; n_state = 0; n_warm = 0; n_settle = 0; n_idle = 0; n_last = m_last;
    end
    rdy = (m_state != 0);
    ck  = (m_state != 1) || (r != 0) || (IDLE_REFRESH != 0);
    sb.push_back({g, u, rdy, ck});
  endtask

  task automatic model_commit();
    m_state = n_state; m_warm = n_warm; m_settle = n_settle; m_idle = n_idle; m_last = n_last;
  endtask

  // One clock cycle: drive, predict, sample at the falling edge, advance.
  task automatic cycle(input logic [NREQ-1:0] r, input logic f);
    logic [EW-1:0] e;
    req = r; flush = f;
    model_step(r, f);
    @(negedge g_clk);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("gnt", 32'(gnt), 32'(e[EW-1:3]));
      check("upd", 32'(rng_update), 32'(e[2]));
      check("rdy", 32'(rng_ready), 32'(e[1]));
      check("clkreq", 32'(g_clk_req), 32'(e[0]));
    end
    log_gnt[cyc] = gnt; log_upd[cyc] = rng_update; log_rdy[cyc] = rng_ready;
    @(posedge g_clk);
    model_commit();
    cyc++;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_upd"}, 32'(rng_update), 32'd0);
    check({tag, "_rdy"}, 32'(rng_ready), 32'd0);
    check({tag, "_clkreq"}, 32'(g_clk_req), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ucyc[$];
    int nz, cnt, first_g;
    g_resetn = 1'b0; req = '0; flush = 1'b0;
    model_reset();
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    check_reset_outputs("rst");
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    cyc = 0;

    // Warm-up with no requests: WARM 0..7, SETTLE 8, READY from 9
    repeat (12) cycle('0, 1'b0);
    for (int i = 0; i < WARMUP; i++) check("warm_upd", 32'(log_upd[i]), 32'd1);
    check("warm_end_upd", 32'(log_upd[8]), 32'd0);
    check("rdy_c7", 32'(log_rdy[7]), 32'd0);
    check("rdy_c8", 32'(log_rdy[8]), 32'd1);
    check("rdy_c9", 32'(log_rdy[9]), 32'd1);

    // Both requesting from READY (cycle 12): alternate grants two cycles apart
    repeat (8) cycle(2'b11, 1'b0);
    check("rr_g12", 32'(log_gnt[12]), 32'd1);
    check("rr_g13", 32'(log_gnt[13]), 32'd0);
    check("rr_g14", 32'(log_gnt[14]), 32'd2);
    check("rr_g16", 32'(log_gnt[16]), 32'd1);
    check("rr_g18", 32'(log_gnt[18]), 32'd2);
    for (int i = 12; i <= 18; i += 2) check("rr_upd", 32'(log_upd[i]), 32'd1);

    // Single requester with last=1: immediate grant; both during SETTLE -> 01 next
    cycle(2'b10, 1'b0);
    cycle(2'b11, 1'b0);
    cycle(2'b11, 1'b0);
    check("lat0_g20", 32'(log_gnt[20]), 32'd2);
    check("settle_g21", 32'(log_gnt[21]), 32'd0);
    check("next_g22", 32'(log_gnt[22]), 32'd1);

    // Idle refresh: 16 READY cycles (refresh in the last) then 1 SETTLE between pulses
    repeat (40) cycle('0, 1'b0);
    nz = 0;
    for (int i = 23; i <= 62; i++) begin
      if (log_upd[i]) ucyc.push_back(i);
      if (log_gnt[i] != 0) nz++;
    end
    check("idle_pulses", 32'(ucyc.size()), 32'd2);
    if (ucyc.size() == 2) begin
      check("idle_first", 32'(ucyc[0]), 32'd39);
      check("idle_period", 32'(ucyc[1] - ucyc[0]), 32'd17);
    end
    check("idle_nogrant", 32'(nz), 32'd0);

    // Flush coinciding with a pending grant, then a full warm-up before the next grant
    cycle(2'b01, 1'b1);
    repeat (10) cycle(2'b01, 1'b0);
    check("flush_gnt", 32'(log_gnt[63]), 32'd0);
    check("flush_upd", 32'(log_upd[63]), 32'd0);
    check("flush_rdy63", 32'(log_rdy[63]), 32'd1);
    check("flush_rdy64", 32'(log_rdy[64]), 32'd0);
    first_g = -1; cnt = 0;
    for (int i = 64; i <= 73; i++) begin
      if (first_g < 0 && log_gnt[i] != 0) first_g = i;
      if (first_g < 0 && log_upd[i]) cnt++;
    end
    check("flush_warm_pulses", 32'(cnt), 32'd8);
    check("flush_first_grant", 32'(first_g), 32'd73);
    check("flush_grant_val", 32'(log_gnt[73]), 32'd1);

    // Asynchronous reset pulse in the middle of SETTLE
    req = '0;
    #2;
    g_resetn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    sb.delete();
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    cyc = 0;
    repeat (10) cycle('0, 1'b0);
    cnt = 0;
    for (int i = 0; i < WARMUP; i++) if (log_upd[i]) cnt++;
    check("rewarm_pulses", 32'(cnt), 32'd8);
    check("rewarm_end", 32'(log_upd[8]), 32'd0);
    check("rewarm_rdy", 32'(log_rdy[8]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
